// File: rtl/bcd_serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_serial_addsub
//  Description : Digit-serial BCD adder/subtractor. It processes one decimal
//                digit per clock, least-significant digit first. Subtraction
//                adds the nine's complement of B with a carry-in of 1. On a
//                borrow, Sum holds the ten's complement of the result.
//                Optional macro BCD_INVALID_CHECK_EN enables the flag for
//                non-BCD operand nibbles. It drives the Error output.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic                  sub_i,
  input  logic [4*DIGITS-1:0]   a_i,
  input  logic [4*DIGITS-1:0]   b_i,
  output logic [4*DIGITS-1:0]   sum_o,
  output logic                  cout_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [4*DIGITS-1:0] a_q, b_q, work_q, work_d, sum_q;
  logic                sub_q, carry_q, carry_d;
  logic                cout_q, busy_q, done_q;

  logic [3:0]          a_dig, b_dig, b_eff, res_dig;
  logic [4:0]          t_sum;
  logic                last_digit, accept, finish;

  // A Start is honoured in any state except RUN; the last RUN digit finishes the op
  assign accept     = start_i && (state_q != RUN);
  assign last_digit = (idx_q == IDX_W'(DIGITS - 1));
  assign finish     = (state_q == RUN) && last_digit;

  // Select the current digit pair, add with decimal correction, merge into working value
  always_comb begin
    a_dig  = 4'd0;
    b_dig  = 4'd0;
    work_d = work_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_dig = a_q[4*i +: 4];
        b_dig = b_q[4*i +: 4];
      end
    end
    b_eff = sub_q ? (4'd9 - b_dig) : b_dig;
    t_sum = {1'b0, a_dig} + {1'b0, b_eff} + {4'd0, carry_q};
    if (t_sum > 5'd9) begin
      res_dig = t_sum[3:0] + 4'd6;
      carry_d = 1'b1;
    end else begin
      res_dig = t_sum[3:0];
      carry_d = 1'b0;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        work_d[4*i +: 4] = res_dig;
      end
    end
  end

  // Control FSM plus operand, working and result registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      work_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (accept) begin
            state_q <= RUN;
            a_q     <= a_i;
            b_q     <= b_i;
            sub_q   <= sub_i;
            carry_q <= sub_i;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          work_q  <= work_d;
          carry_q <= carry_d;
          idx_q   <= idx_q + IDX_W'(1);
          if (finish) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= work_d;
            cout_q  <= sub_q ? ~carry_d : carry_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef BCD_INVALID_CHECK_EN
  logic inv_d, inv_q, error_q;

  // Flag any nibble above 9 in either operand at the moment of acceptance
  always_comb begin
    inv_d = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((a_i[4*i +: 4] > 4'd9) || (b_i[4*i +: 4] > 4'd9)) begin
        inv_d = 1'b1;
      end
    end
  end

  // Hold the flag for the operation in flight and publish it on completion
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      inv_q   <= 1'b0;
      error_q <= 1'b0;
    end else begin
      if (accept) begin
        inv_q <= inv_d;
      end
      if (finish) begin
        error_q <= inv_q;
      end
    end
  end

  assign error_o = error_q;
`else
  assign error_o = 1'b0;
`endif

  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_serial_addsub
//  Description : Self-checking bench for bcd_serial_addsub. It covers a
//                DIGITS=4 instance and a DIGITS=1 instance. A decimal-arithmetic
//                model predicts the timeline and results for every cycle.
//                Directed vectors check literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_serial_addsub;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, sub;
  logic [15:0] a, b;
  logic [15:0] sum;
  logic        cout, busy, done, err;

  logic        start1, sub1;
  logic [3:0]  a1, b1, sum1;
  logic        cout1, busy1, done1, err1;

  int total = 0;
  int bad   = 0;

  bcd_serial_addsub #(.DIGITS(4)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .sub_i(sub),
    .a_i(a), .b_i(b), .sum_o(sum), .cout_o(cout), .busy_o(busy),
    .done_o(done), .error_o(err)
  );

  bcd_serial_addsub #(.DIGITS(1)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start1), .sub_i(sub1),
    .a_i(a1), .b_i(b1), .sum_o(sum1), .cout_o(cout1), .busy_o(busy1),
    .done_o(done1), .error_o(err1)
  );

  always #5 clk = ~clk;

  // ---------------- decimal model ----------------
  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int n);
    logic [15:0] r;
    int m = n;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic has_bad(input logic [15:0] x, input logic [15:0] y);
    logic f = 1'b0;
    for (int i = 0; i < 4; i++)
      if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) f = 1'b1;
    return f;
  endfunction

  // returns {cout, sum}
  function automatic logic [16:0] model_op(input logic [15:0] x, input logic [15:0] y,
                                           input logic s);
    int av = bcd2int(x);
    int bv = bcd2int(y);
    int r;
    if (!s) begin
      r = av + bv;
      return {(r >= 10000), int2bcd(r % 10000)};
    end
    if (av >= bv) return {1'b0, int2bcd(av - bv)};
    return {1'b1, int2bcd(10000 + av - bv)};
  endfunction

  int          m_phase;   // 0 idle, 1..D running, D+1 done
  logic [16:0] p_res, m_res;
  logic        p_known, m_known, p_err, m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_res   <= '0;
      m_known <= 1'b1;
      m_err   <= 1'b0;
    end else if ((m_phase == 0 || m_phase == D + 1) && start) begin
      m_phase <= 1;
      p_res   <= model_op(a, b, sub);
      p_known <= !has_bad(a, b);
`ifdef BCD_INVALID_CHECK_EN
      p_err   <= has_bad(a, b);
`else
      p_err   <= 1'b0;
`endif
    end else if (m_phase >= 1 && m_phase < D) begin
      m_phase <= m_phase + 1;
    end else if (m_phase == D) begin
      m_phase <= D + 1;
      m_res   <= p_res;
      m_known <= p_known;
      m_err   <= p_err;
    end else begin
      m_phase <= 0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic eb, ed;
    eb = (m_phase >= 1 && m_phase <= D);
    ed = (m_phase == D + 1);
    total++;
    if ({busy, done, err} !== {eb, ed, m_err}) begin
      bad++;
      $display("FAIL cycle_ctrl t=%0t busy/done/err got=%b%b%b expected=%b%b%b",
               $time, busy, done, err, eb, ed, m_err);
    end
    if (m_known) begin
      total++;
      if ({cout, sum} !== m_res) begin
        bad++;
        $display("FAIL cycle_result t=%0t got cout=%b sum=%h expected cout=%b sum=%h",
                 $time, cout, sum, m_res[16], m_res[15:0]);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic op(input logic [15:0] x, input logic [15:0] y, input logic s);
    @(negedge clk);
    a = x; b = y; sub = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 16'hFFFF; b = 16'hEEEE; sub = ~s;
  endtask

  task automatic wait_done(input string nm, input logic [15:0] es, input logic ec,
                           input logic chk_res, input logic ee, output int n);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s_timeout got=no_done expected=done", nm);
    end else begin
      if (chk_res) begin
        chk({nm, "_sum"}, 32'(sum), 32'(es));
        chk({nm, "_cout"}, 32'(cout), 32'(ec));
      end
      chk({nm, "_err"}, 32'(err), 32'(ee));
    end
  endtask

  logic ee_inv;

  initial begin
    int n;
`ifdef BCD_INVALID_CHECK_EN
    ee_inv = 1'b1;
`else
    ee_inv = 1'b0;
`endif
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    chk("reset_sum", 32'(sum), 32'h0);
    chk("reset_flags", {28'd0, cout, busy, done, err}, 32'h0);
    rst_n = 1'b1;

    op(16'h1234, 16'h5678, 1'b0);
    chk("add_busy_first", 32'(busy), 32'h1);
    wait_done("add", 16'h6912, 1'b0, 1'b1, 1'b0, n);
    chk("add_latency", 32'(n), 32'd4);

    op(16'h9999, 16'h0001, 1'b0);
    wait_done("ripple", 16'h0000, 1'b1, 1'b1, 1'b0, n);
    op(16'h5000, 16'h1234, 1'b1);
    wait_done("sub_nb", 16'h3766, 1'b0, 1'b1, 1'b0, n);
    op(16'h1234, 16'h5000, 1'b1);
    wait_done("sub_b", 16'h6234, 1'b1, 1'b1, 1'b0, n);

    // Start during RUN is ignored
    op(16'h1234, 16'h5678, 1'b0);
    a = 16'h1111; b = 16'h2222; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignored", 16'h6912, 1'b0, 1'b1, 1'b0, n);
    // back-to-back start in the Done cycle
    a = 16'h4444; b = 16'h1111; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("b2b", 16'h5555, 1'b0, 1'b1, 1'b0, n);
    chk("b2b_latency", 32'(n + 1), 32'd5);

    // reset in the second RUN cycle
    op(16'h1234, 16'h5678, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sum", 32'(sum), 32'h0);
    chk("midrst_flags", {28'd0, cout, busy, done, err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(done), 32'h0);
    end
    op(16'h0001, 16'h0001, 1'b0);
    wait_done("after_rst", 16'h0002, 1'b0, 1'b1, 1'b0, n);

    // invalid nibble
    op(16'h00A0, 16'h0000, 1'b0);
    wait_done("invalid", 16'h0000, 1'b0, 1'b0, ee_inv, n);
    op(16'h0002, 16'h0003, 1'b0);
    wait_done("valid_after", 16'h0005, 1'b0, 1'b1, 1'b0, n);

    // single-digit instance
    @(negedge clk);
    a1 = 4'd7; b1 = 4'd5; sub1 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("d1_busy", {30'd0, busy1, done1}, 32'h2);
    @(negedge clk);
    chk("d1_done", {27'd0, done1, cout1, sum1}, {27'd0, 1'b1, 1'b1, 4'd2});
    a1 = 4'd3; b1 = 4'd5; sub1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    chk("d1_sub", {27'd0, done1, cout1, sum1}, {27'd0, 1'b1, 1'b1, 4'd8});

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_serial_addsub.md
BCD_SERIAL_ADDSUB -- requirements
Module: bcd_serial_addsub

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, giving the number of BCD digits per operand; legal range 1..16.
REQ-002 Clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 Rst_n  input  1  asynchronous, active-low reset.
REQ-004 Start  input  1  request to begin an operation, sampled on the rising edge of Clk.
REQ-005 Sub  input  1  operation select, sampled with Start: 0 = A+B, 1 = A-B.
REQ-006 A  input  4*DIGITS  BCD operand; digit 0 is bits [3:0] and is least significant.
REQ-007 B  input  4*DIGITS  BCD operand, same digit layout as A.
REQ-008 Sum  output  4*DIGITS  registered BCD result, held between operations.
REQ-009 Cout  output  1  add: decimal carry out; sub: borrow (A<B), in which case Sum holds the 10's complement.
REQ-010 Busy  output  1  high while digits are being processed.
REQ-011 Done  output  1  one-cycle pulse when Sum, Cout and Error are valid.
REQ-012 Error  output  1  invalid-digit flag (see Configuration).

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
REQ-014 In IDLE or DONE, Start=1 SHALL latch A, B and Sub into internal registers, clear the digit index, and enter RUN.
  - Carry SHALL be initialised to Sub.
REQ-015 In RUN, the block SHALL process one digit per clock, least-significant digit first.
  - Operand b = B digit when Sub=0, or 9 minus the B digit when Sub=1.
  - t = A digit + b + carry.
  - If t>9: result digit = t+6 (low 4 bits), carry = 1; else result digit = t, carry = 0.
REQ-016 Each result digit SHALL be written into its position in the working register, and the index SHALL increment.
  - After digit DIGITS-1 is processed, the FSM SHALL enter DONE.
REQ-017 On entering DONE:
  - Sum SHALL be loaded from the working register.
  - Cout SHALL be loaded with the final carry when Sub=0, or its inverse when Sub=1.
REQ-018 Done SHALL be high for exactly the one cycle the FSM is in DONE.
  - Without a new Start, DONE SHALL go to IDLE.
REQ-019 Latency: Start sampled at edge k; Busy SHALL be high for cycles k+1 to k+DIGITS; Done SHALL be high in cycle k+DIGITS+1.
REQ-020 Start while in RUN SHALL be ignored; the operation in flight and the latched operands SHALL be unaffected.
REQ-021 Start in the DONE cycle SHALL be accepted, giving back-to-back operations with no idle cycle.
REQ-022 Sum, Cout and Error SHALL hold their last values until the next entry into DONE.
  - Changes on A, B and Sub outside a Start sample SHALL have no effect.
REQ-023 Non-BCD input nibbles (>9) SHALL still be processed with the same correction rule; the result is undefined but the FSM SHALL NOT stall.

Reset
REQ-024 Rst_n low SHALL, asynchronously and in any state including mid-RUN, force:
  - FSM to IDLE, digit index to 0;
  - Sum, working register and operand registers to 0;
  - Cout, Busy, Done, Error to 0.
REQ-025 After Rst_n is released, the first Start SHALL be accepted on the first rising edge at which it is sampled high.

Configuration
REQ-026 Macro BCD_INVALID_CHECK_EN defined: any nibble of A or B greater than 9 at the Start sample SHALL set a sticky internal flag, copied to Error on entry to DONE; the flag SHALL be cleared at each accepted Start.
REQ-027 Macro BCD_INVALID_CHECK_EN undefined: Error SHALL be tied to 0, no check logic SHALL be present, and the port list SHALL be unchanged.

Verification (DIGITS=4 unless stated)
REQ-028 Add: A=1234, B=5678, Sub=0, Start at edge k -> Busy high for 4 cycles; Done in cycle k+5 with Sum=6912, Cout=0.
REQ-029 Carry ripple: A=9999, B=0001, Sub=0 -> Sum=0000, Cout=1.
  - Sub, no borrow: A=5000, B=1234, Sub=1 -> Sum=3766, Cout=0.
  - Sub, borrow: A=1234, B=5000, Sub=1 -> Sum=6234, Cout=1.
REQ-030 Busy/back-to-back: Start re-asserted with A=1111, B=2222 during RUN of 1234+5678 -> ignored, Sum=6912.
  - Start 4444+1111 in the Done cycle -> next Done exactly 5 cycles later with Sum=5555.
REQ-031 Reset mid-op: Rst_n pulsed low in the 2nd RUN cycle -> all outputs 0 immediately, no Done; a fresh 0001+0001 -> Sum=0002.
REQ-032 With BCD_INVALID_CHECK_EN: A=00A0, B=0000 -> Error=1 at Done; the next valid operation -> Error=0.
  - Without the macro, Error stays 0 for the same stimulus.
REQ-033 DIGITS=1: 7+5, Sub=0 -> Done 2 cycles after Start, Sum=2, Cout=1.
